vga_rx_monitor: RTL
===================

Name: vga_rx_monitor

Overview:
- Receive-side decoder for the 12-bit RGB + hsync/vsync VGA pixel stream that the Trinity core drives.
- Used in loopback self-test and in the simulation bench. Taps the VGA pins in the same clock domain.
- Recovers timing, locks to the raster and emits pixel coordinates with colour for active pixels.
- Flags line-length and frame-length deviations from the configured mode.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are low-true
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (range 1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-clock enable; inputs are sampled only when pix_en=1
- io_vga_r  in  4  red
- io_vga_g  in  4  green
- io_vga_b  in  4  blue
- io_vga_hsync  in  1  horizontal sync
- io_vga_vsync  in  1  vertical sync
- err_clr  in  1  clears sticky error flags
- pixel_valid  out  1  active pixel on pixel_x/pixel_y/pixel_rgb this cycle
- pixel_x  out  11  column, 0..H_ACTIVE-1
- pixel_y  out  11  row, 0..V_ACTIVE-1
- pixel_rgb  out  12  {r,g,b}
- frame_start  out  1  one-cycle pulse at each detected frame start
- locked  out  1  raster lock status
- err_hlen  out  1  sticky: measured line length != H_TOTAL
- err_vlen  out  1  sticky: measured frame length != V_TOTAL

Behaviour:
- Derived constants: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*. Syncs are normalised internally to active-high via SYNC_ACTIVE_LOW.
- Sampling: all state advances only on cycles with pix_en=1. On pix_en=0, state holds and pixel_valid and frame_start are 0.
- Output latency: every output is registered, one clock after the pix_en sample that produced it.
- hcnt (12b):
  - Set to 0 on an hsync leading edge (inactive->active between consecutive samples).
  - Otherwise increments, saturating at 4095.
- Line check at each hsync leading edge: if previous hcnt+1 != H_TOTAL and state != SEARCH, set err_hlen.
- vcnt (11b):
  - Increments at each hsync leading edge, saturating at 2047.
  - Frame start = hsync leading edge where vsync is active and vsync was inactive at the previous hsync leading edge. On frame start: vcnt=0 and frame_start pulses.
- Frame check at frame start: if previous vcnt+1 != V_TOTAL and state != SEARCH, set err_vlen.
- Active pixel: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - pixel_x = hcnt-(H_SYNC+H_BP); pixel_y = vcnt-(V_SYNC+V_BP); pixel_rgb = sampled colour.
- State machine:
  - SEARCH -> ALIGN on first frame start; good-frame counter cleared.
  - ALIGN: each frame start with no line or frame error in the completed frame increments the counter; any error returns to SEARCH. When the counter reaches LOCK_FRAMES -> LOCKED, and locked=1 from that frame-start cycle.
  - LOCKED: any line or frame error -> SEARCH with locked=0 in the same output cycle as the error flag.
  - pixel_valid only in LOCKED.
- Sticky errors: err_clr clears them. A new error in the same cycle as err_clr wins; the flag stays 1.
- Reset (any time, including mid-frame):
  - state=SEARCH; hcnt=0; vcnt=0; previous-sync registers=inactive.
  - All outputs 0: pixel_x, pixel_y, pixel_rgb, pixel_valid, frame_start, locked, err_hlen, err_vlen.
  - Errors from before reset are not retained.

Optional Feature:
- Macro VGA_RX_FRAME_CRC_EN.
- When defined:
  - Adds outputs frame_crc (16b) and crc_valid (1b).
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final xor) over the 12-bit pixel_rgb of every active pixel in LOCKED, zero-extended to 16b, MSB first.
  - At each frame start in LOCKED: frame_crc takes the finished value, crc_valid pulses for 1 cycle, accumulator re-inits.
  - Reset: frame_crc=0, crc_valid=0.
- When undefined: ports and logic are absent.

Test Plan:
- Ideal 640x480 stream, pix_en=1 every cycle, 4 frames:
  - locked rises at the 3rd frame start.
  - Exactly 307200 pixel_valid per locked frame.
  - First pixel has x=0, y=0; last has x=639, y=479.
  - pixel_rgb equals the driven value one cycle later.
  - No errors.
- pix_en alternating 1/0 with the same stream: identical pixel count and lock timing in sample units; no pixel_valid on pix_en=0 cycles.
- In LOCKED, shorten one line to 799 samples:
  - err_hlen=1 and locked=0 in the same cycle.
  - Relocks after 2 good frames.
  - err_hlen remains 1 until err_clr.
- err_clr asserted in the same cycle as a 526-line frame's frame start: err_vlen stays 1. err_clr on a later clean cycle: err_vlen=0.
- Reset pulsed mid-frame in LOCKED:
  - Next cycle all outputs are 0 and state is SEARCH.
  - locked returns at the 3rd frame start after reset.
- With VGA_RX_FRAME_CRC_EN, frames of constant colour 0xABC:
  - Successive frame_crc values are equal.
  - Changing pixel (10,20) to 0xABD changes that frame's frame_crc.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: samples a 12-bit RGB + hsync/vsync stream, locks to the raster and
// reports active pixels plus sticky line/frame length errors. Define VGA_RX_FRAME_CRC_EN for per-frame CRC-16.
module vga_rx_monitor #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [3:0]  io_vga_r,
  input  logic [3:0]  io_vga_g,
  input  logic [3:0]  io_vga_b,
  input  logic        io_vga_hsync,
  input  logic        io_vga_vsync,
  input  logic        err_clr,
  output logic        pixel_valid,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err_hlen,
`ifdef VGA_RX_FRAME_CRC_EN
  output logic        err_vlen,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`else
  output logic        err_vlen
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END   = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic        SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_good_cnt;
  logic [3:0]  w_good_next;
  logic [3:0]  w_good_inc;

  logic [11:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic        r_hs_prev;
  logic        r_vs_at_edge;

  logic        r_pixel_valid;
  logic [10:0] r_pixel_x;
  logic [10:0] r_pixel_y;
  logic [11:0] r_pixel_rgb;
  logic        r_frame_start;
  logic        r_err_hlen;
  logic        r_err_vlen;

  logic        w_hs;
  logic        w_vs;
  logic [11:0] w_rgb;
  logic        w_hs_edge;
  logic        w_frame_start;
  logic        w_hlen_bad;
  logic        w_vlen_bad;
  logic        w_line_err;
  logic        w_frame_err;
  logic [11:0] w_hcnt_next;
  logic [10:0] w_vcnt_next;
  logic        w_active;
  logic [11:0] w_px;
  logic [10:0] w_py;

  // Syncs normalised to active-high; every event below is qualified by pix_en.
  assign w_hs  = io_vga_hsync ^ SYNC_INV;
  assign w_vs  = io_vga_vsync ^ SYNC_INV;
  assign w_rgb = {io_vga_r, io_vga_g, io_vga_b};

  assign w_hs_edge     = pix_en & w_hs & ~r_hs_prev;
  assign w_frame_start = w_hs_edge & w_vs & ~r_vs_at_edge;
  assign w_hlen_bad    = (({1'b0, r_hcnt} + 13'd1) != 13'(H_TOTAL));
  assign w_vlen_bad    = (({1'b0, r_vcnt} + 12'd1) != 12'(V_TOTAL));
  assign w_line_err    = w_hs_edge & w_hlen_bad & (r_state != ST_SEARCH);
  assign w_frame_err   = w_frame_start & w_vlen_bad & (r_state != ST_SEARCH);

  always_comb begin
    w_hcnt_next = r_hcnt;
    w_vcnt_next = r_vcnt;
    if (w_hs_edge) begin
      w_hcnt_next = '0;
    end else if (r_hcnt != 12'hFFF) begin
      w_hcnt_next = r_hcnt + 12'd1;
    end
    if (w_frame_start) begin
      w_vcnt_next = '0;
    end else if (w_hs_edge && (r_vcnt != 11'h7FF)) begin
      w_vcnt_next = r_vcnt + 11'd1;
    end
  end

  assign w_active = (w_hcnt_next >= H_START) && (w_hcnt_next <= H_END) &&
                    (w_vcnt_next >= V_START) && (w_vcnt_next <= V_END);
  assign w_px     = w_hcnt_next - H_START;
  assign w_py     = w_vcnt_next - V_START;

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    w_good_inc   = r_good_cnt + 4'd1;
    unique case (r_state)
      ST_SEARCH: begin
        if (w_frame_start) begin
          w_state_next = ST_ALIGN;
          w_good_next  = '0;
        end
      end
      ST_ALIGN: begin
        if (w_line_err || w_frame_err) begin
          w_state_next = ST_SEARCH;
        end else if (w_frame_start) begin
          w_good_next = w_good_inc;
          if (w_good_inc >= 4'(LOCK_FRAMES)) begin
            w_state_next = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_line_err || w_frame_err) begin
          w_state_next = ST_SEARCH;
        end
      end
      default: w_state_next = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_good_cnt <= w_good_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hs_prev     <= 1'b0;
      r_vs_at_edge  <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_pixel_rgb   <= '0;
      r_frame_start <= 1'b0;
      r_err_hlen    <= 1'b0;
      r_err_vlen    <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_en) begin
        r_hcnt        <= w_hcnt_next;
        r_vcnt        <= w_vcnt_next;
        r_hs_prev     <= w_hs;
        r_frame_start <= w_frame_start;
        if (w_hs_edge) begin
          r_vs_at_edge <= w_vs;
        end
        if (w_active && (r_state == ST_LOCKED)) begin
          r_pixel_valid <= 1'b1;
          r_pixel_x     <= w_px[10:0];
          r_pixel_y     <= w_py;
          r_pixel_rgb   <= w_rgb;
        end
        // A fresh error outranks a simultaneous clear.
        if (w_line_err) begin
          r_err_hlen <= 1'b1;
        end else if (err_clr) begin
          r_err_hlen <= 1'b0;
        end
        if (w_frame_err) begin
          r_err_vlen <= 1'b1;
        end else if (err_clr) begin
          r_err_vlen <= 1'b0;
        end
      end
    end
  end

  assign pixel_valid = r_pixel_valid;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign pixel_rgb   = r_pixel_rgb;
  assign frame_start = r_frame_start;
  assign locked      = (r_state == ST_LOCKED);
  assign err_hlen    = r_err_hlen;
  assign err_vlen    = r_err_vlen;

`ifdef VGA_RX_FRAME_CRC_EN
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  logic [15:0] r_crc_acc;
  logic [15:0] r_frame_crc;
  logic        r_crc_valid;

  // Bit-serial CCITT update, data word consumed MSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [15:0] data);
    logic [15:0] crc;
    logic        fb;
    crc = crc_in;
    for (int i = 15; i >= 0; i--) begin
      fb  = crc[15] ^ data[i];
      crc = {crc[14:0], 1'b0};
      if (fb) begin
        crc = crc ^ CRC_POLY;
      end
    end
    return crc;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_crc_acc   <= CRC_INIT;
      r_frame_crc <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      r_crc_valid <= 1'b0;
      if (pix_en) begin
        if (w_frame_start) begin
          if (r_state == ST_LOCKED) begin
            r_frame_crc <= r_crc_acc;
            r_crc_valid <= 1'b1;
          end
          r_crc_acc <= CRC_INIT;
        end else if (w_active && (r_state == ST_LOCKED)) begin
          r_crc_acc <= crc16_word(r_crc_acc, {4'h0, w_rgb});
        end
      end
    end
  end

  assign frame_crc = r_frame_crc;
  assign crc_valid = r_crc_valid;
`endif

endmodule
